// File: rtl/fifo_rd_arbiter_if.sv
// Bundle of signals between the FIFO read side, the arbiter and the two
// consumers. The arbiter uses the master view; the environment (FIFO and
// consumers) uses the slave view.
interface fifo_rd_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              fifo_empty;
  logic              fifo_rd_req;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              req0;
  logic              req1;
  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] dout;
  logic              dout_valid0;
  logic              dout_valid1;
  logic              done0;
  logic              done1;
  logic              busy;

  modport master (
    input  fifo_empty, fifo_rd_data, req0, req1,
    output fifo_rd_req, grant0, grant1, dout,
           dout_valid0, dout_valid1, done0, done1, busy
  );

  modport slave (
    output fifo_empty, fifo_rd_data, req0, req1,
    input  fifo_rd_req, grant0, grant1, dout,
           dout_valid0, dout_valid1, done0, done1, busy
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin burst arbiter sharing the read port of one show-ahead-off FIFO
// between two consumers. Each grant reads up to BURST_LEN words; the FIFO's
// one-cycle read latency is absorbed by a two-cycle DRAIN phase so every word
// requested during a burst is delivered to its owner before done pulses.
module fifo_rd_arbiter #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_rd_arbiter_if.master  io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX  = CNT_W'(BURST_LEN);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rr_ptr;
  logic              r_owner;
  logic              r_drain_last;
  logic [1:0]        r_grant;
  logic [1:0]        r_done;
  logic              r_rd_req_d;
  logic [DATA_W-1:0] r_dout;

  logic [1:0]        w_req;
  logic              w_req_owner;
  logic              w_sel_owner;
  logic              w_rd_req;
  logic              w_last_req;
  logic [1:0]        w_valid;

  assign w_req       = {io_bus.req1, io_bus.req0};
  assign w_req_owner = w_req[r_owner];
  // Single requester wins outright; on a tie the round-robin pointer decides.
  assign w_sel_owner = (&w_req) ? r_rr_ptr : w_req[1];

  // Read request is combinational so an empty FIFO or a dropped request
  // suppresses the pop in the very cycle it happens.
  assign w_rd_req   = (r_state == ST_BURST) & ~io_bus.fifo_empty & w_req_owner
                    & (r_cnt != LP_CNT_MAX);
  assign w_last_req = w_rd_req & (r_cnt == LP_CNT_LAST);

  // Burst control FSM: owner selection, word counting, drain and done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rr_ptr     <= 1'b0;
      r_owner      <= 1'b0;
      r_drain_last <= 1'b0;
      r_grant      <= '0;
      r_done       <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_state <= ST_BURST;
            r_owner <= w_sel_owner;
            r_cnt   <= '0;
            r_grant <= w_sel_owner ? 2'b10 : 2'b01;
          end
        end
        ST_BURST: begin
          if (w_rd_req) begin
            r_cnt <= r_cnt + 1'b1;
          end
          // Either the final word went out or the owner gave up early.
          if (w_last_req || !w_req_owner) begin
            r_state      <= ST_DRAIN;
            r_drain_last <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!r_drain_last) begin
            // Done lands in the second drain cycle, together with the last
            // possible valid word.
            r_drain_last     <= 1'b1;
            r_done[r_owner]  <= 1'b1;
          end else begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= ~r_owner;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-latency pipe: remember the request, then capture the returned word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_req_d <= 1'b0;
      r_dout     <= '0;
    end else begin
      r_rd_req_d <= w_rd_req;
      if (r_rd_req_d) begin
        r_dout <= io_bus.fifo_rd_data;
      end
    end
  end

  // Per-consumer valid strobe, routed by the owner held through DRAIN.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cons
    logic r_valid;

    // Valid follows the captured word for the consumer that owns the burst.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_rd_req_d & (r_owner == 1'(gi));
      end
    end

    assign w_valid[gi] = r_valid;
  end

  assign io_bus.fifo_rd_req = w_rd_req;
  assign io_bus.grant0      = r_grant[0];
  assign io_bus.grant1      = r_grant[1];
  assign io_bus.dout        = r_dout;
  assign io_bus.dout_valid0 = w_valid[0];
  assign io_bus.dout_valid1 = w_valid[1];
  assign io_bus.done0       = r_done[0];
  assign io_bus.done1       = r_done[1];
  assign io_bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Bench for fifo_rd_arbiter: a queue-based FIFO, directed scenarios and a
// random phase, all checked against a timeline model of bursts.
module tb_fifo_rd_arbiter;

  localparam int BL = 16;

  typedef struct {
    longint     at;
    int         own;
    logic [7:0] data;
  } dlv_t;

  logic clk;
  logic rst_n;

  fifo_rd_arbiter_if #(.DATA_W(8)) bus ();

  fifo_rd_arbiter #(.DATA_W(8), .BURST_LEN(BL), .CNT_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // environment state
  logic [7:0] fq[$];
  bit  pop_pend, want0, want1, want_rst, force_empty;
  longint cyc = 0;

  // model state
  int         m_owner, m_words, m_rr;
  bit         m_reading;
  longint     m_done_at, m_release_at;
  logic [7:0] m_dout;
  dlv_t       dq[$];

  // observed counters
  int n_v0, n_v1, n_rd, n_dn0, n_dn1, b_rd, b_v;
  logic [7:0] fd0, fd1;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_reading = 0; m_words = 0; m_rr = 0;
    m_done_at = -1; m_release_at = -1; m_dout = '0;
    dq.delete();
  endtask

  task automatic clr_cnt();
    n_v0 = 0; n_v1 = 0; n_rd = 0; n_dn0 = 0; n_dn1 = 0; b_rd = 0; b_v = 0;
    fd0 = '0; fd1 = '0;
  endtask

  task automatic step_cycle();
    dlv_t d, nd;
    bit e_rd, e_v0, e_v1, req_own;
    @(negedge clk);
    if (pop_pend && fq.size() > 0) bus.fifo_rd_data = fq.pop_front();
    rst_n          = ~want_rst;
    bus.req0       = want0;
    bus.req1       = want1;
    bus.fifo_empty = (fq.size() == 0) || force_empty;
    #1;
    // expectations for this cycle
    req_own = (m_owner == 1) ? bus.req1 : bus.req0;
    e_rd = m_reading && !bus.fifo_empty && req_own && (m_words < BL);
    e_v0 = 0; e_v1 = 0;
    if (dq.size() > 0 && dq[0].at == cyc) begin
      d = dq.pop_front();
      if (d.own == 0) e_v0 = 1; else e_v1 = 1;
      m_dout = d.data;
    end
    chk_eq("grant0", bus.grant0, m_owner == 0);
    chk_eq("grant1", bus.grant1, m_owner == 1);
    chk_eq("busy", bus.busy, m_owner >= 0);
    chk_eq("rd_req", bus.fifo_rd_req, e_rd);
    chk_eq("valid0", bus.dout_valid0, e_v0);
    chk_eq("valid1", bus.dout_valid1, e_v1);
    chk_eq("done0", bus.done0, m_owner == 0 && cyc == m_done_at);
    chk_eq("done1", bus.done1, m_owner == 1 && cyc == m_done_at);
    chk_eq("dout", bus.dout, m_dout);
    chk_eq("grant_mutex", bus.grant0 & bus.grant1, 0);
    chk_eq("valid_mutex", bus.dout_valid0 & bus.dout_valid1, 0);
    chk_eq("rd_when_empty", bus.fifo_rd_req & bus.fifo_empty, 0);
    // observed bookkeeping
    pop_pend = (bus.fifo_rd_req === 1'b1);
    if (bus.fifo_rd_req === 1'b1) begin n_rd++; b_rd++; end
    if (bus.dout_valid0 === 1'b1) begin if (n_v0 == 0) fd0 = bus.dout; n_v0++; b_v++; end
    if (bus.dout_valid1 === 1'b1) begin if (n_v1 == 0) fd1 = bus.dout; n_v1++; b_v++; end
    if (bus.done0 === 1'b1) n_dn0++;
    if (bus.done1 === 1'b1) n_dn1++;
    if ((bus.done0 | bus.done1) === 1'b1) begin
      chk_eq("burst_max", b_rd <= BL, 1);
      chk_eq("burst_valids", b_v, b_rd);
      $display("cyc=%0d burst done owner=%0d reads=%0d valids=%0d",
               cyc, bus.done1 ? 1 : 0, b_rd, b_v);
      b_rd = 0; b_v = 0;
    end
    // advance the model to the next cycle
    if (!rst_n) begin
      model_reset();
      b_rd = 0; b_v = 0;
    end else begin
      if (e_rd) begin
        nd.at = cyc + 2; nd.own = m_owner; nd.data = fq[0];
        dq.push_back(nd);
        m_words++;
      end
      if (m_reading && (!req_own || (e_rd && m_words == BL))) begin
        m_reading = 0; m_done_at = cyc + 2; m_release_at = cyc + 3;
      end
      if (m_owner >= 0) begin
        if (cyc + 1 == m_release_at) begin m_rr = 1 - m_owner; m_owner = -1; end
      end else if (bus.req0 || bus.req1) begin
        m_owner   = (bus.req0 && bus.req1) ? m_rr : (bus.req1 ? 1 : 0);
        m_reading = 1; m_words = 0; m_done_at = -1; m_release_at = -1;
      end
    end
    cyc++;
  endtask

  task automatic run_until_done(input int target, input int max_cyc);
    int k = 0;
    while ((n_dn0 + n_dn1) < target && k < max_cyc) begin step_cycle(); k++; end
    if ((n_dn0 + n_dn1) < target) chk_eq("done_timeout", n_dn0 + n_dn1, target);
  endtask

  task automatic run_until_reads(input int target, input int max_cyc);
    int k = 0;
    while (n_rd < target && k < max_cyc) begin step_cycle(); k++; end
    if (n_rd < target) chk_eq("reads_timeout", n_rd, target);
  endtask

  task automatic do_reset();
    want0 = 0; want1 = 0; force_empty = 0;
    fq.delete();
    want_rst = 1; step_cycle(); want_rst = 0;
    clr_cnt();
  endtask

  task automatic load_fifo(input int first, input int count);
    for (int i = 0; i < count; i++) fq.push_back(8'(first + i));
  endtask

  initial begin
    rst_n = 0; bus.req0 = 0; bus.req1 = 0; bus.fifo_empty = 1; bus.fifo_rd_data = '0;
    pop_pend = 0; want0 = 0; want1 = 0; want_rst = 0; force_empty = 0;
    repeat (3) @(negedge clk);
    model_reset(); clr_cnt();
    repeat (2) step_cycle();          // reset state checked by the model

    // S1: single consumer, full burst of 16 out of 20 words
    do_reset(); load_fifo(0, 20); want0 = 1;
    run_until_done(1, 60); want0 = 0;
    repeat (4) step_cycle();
    chk_eq("s1_valid0", n_v0, 16);
    chk_eq("s1_reads", n_rd, 16);
    chk_eq("s1_first", fd0, 8'h00);
    chk_eq("s1_left", fq.size(), 4);
    chk_eq("s1_done0", n_dn0, 1);

    // S2: both consumers, alternating bursts
    do_reset(); load_fifo(0, 48); want0 = 1; want1 = 1;
    run_until_done(3, 200); want0 = 0; want1 = 0;
    repeat (4) step_cycle();
    chk_eq("s2_valid0", n_v0, 32);
    chk_eq("s2_valid1", n_v1, 16);
    chk_eq("s2_first1", fd1, 8'h10);

    // S3: FIFO runs dry mid-burst, then refilled
    do_reset(); load_fifo(0, 5); want1 = 1;
    repeat (12) step_cycle();
    chk_eq("s3_stalled", n_rd, 5);
    chk_eq("s3_busy", bus.busy, 1);
    load_fifo(5, 11);
    run_until_done(1, 60); want1 = 0;
    repeat (4) step_cycle();
    chk_eq("s3_valid1", n_v1, 16);

    // S4: abort after 7 reads, then round-robin favours consumer 1
    do_reset(); load_fifo(0, 30); want0 = 1;
    run_until_reads(7, 40); want0 = 0;
    step_cycle();
    chk_eq("s4_rd_drop", bus.fifo_rd_req, 0);
    run_until_done(1, 20);
    repeat (2) step_cycle();
    chk_eq("s4_valid0", n_v0, 7);
    chk_eq("s4_reads", n_rd, 7);
    want0 = 1; want1 = 1;
    for (int k = 0; k < 10; k++) begin
      step_cycle();
      if (bus.grant0 || bus.grant1) break;
    end
    chk_eq("s4_rr_grant1", bus.grant1, 1);
    want0 = 0; want1 = 0;
    run_until_done(2, 20);
    repeat (3) step_cycle();

    // S5: reset at cnt=9, then a fresh burst
    do_reset(); load_fifo(0, 40); want0 = 1;
    run_until_reads(9, 40);
    want_rst = 1; step_cycle(); want_rst = 0;
    clr_cnt();
    step_cycle();
    chk_eq("s5_grant_clr", bus.grant0, 0);
    chk_eq("s5_valid_clr", bus.dout_valid0, 0);
    run_until_done(1, 60); want0 = 0;
    repeat (4) step_cycle();
    chk_eq("s5_valid0", n_v0, 16);
    chk_eq("s5_dones", n_dn0 + n_dn1, 1);

    // S6: random requests, empty flag and occasional reset
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 9) == 0) want0 = ~want0;
      if ($urandom_range(0, 9) == 0) want1 = ~want1;
      force_empty = ($urandom_range(0, 3) == 0);
      want_rst    = ($urandom_range(0, 2999) == 0);
      if (fq.size() < 3) for (int j = 0; j < 4; j++) fq.push_back(8'($urandom));
      step_cycle();
    end
    want0 = 0; want1 = 0; force_empty = 0; want_rst = 0;
    repeat (40) step_cycle();
    chk_eq("end_idle", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
